inpkt_parser: RTL and testbench
===============================

// Module: inpkt_parser
// PURPOSE
//  Consumes the 16-bit word stream written by the high-speed USB I/O block (dout/wr_en) and buffers it in a small FIFO.
//  Drives almost_full back to the I/O block, with margin for its 2-cycle write pipeline.
//  Parses framed packets, emits the payload to the core input FIFO via valid/ready, and reports per-packet status and errors.
// PARAMETERS
//  BUF_DEPTH   8      internal word buffer depth; power of 2, >=8
//  AF_MARGIN   3      almost_full asserted when buffer count >= BUF_DEPTH-AF_MARGIN
//  MAX_LEN     1024   max payload length in words; larger length word = error
//  MAGIC       8'h5A  required header[15:8]
// PORTS
//  IFCLK          in   1   sole clock, same domain as USB I/O block
//  rst            in   1   asynchronous reset, active-high
//  din            in   16  word from USB I/O block
//  wr_en          in   1   din valid this cycle; always accepted (no handshake)
//  almost_full    out  1   back-pressure to USB I/O block; registered
//  dout           out  16  payload word
//  dout_valid     out  1   payload word valid
//  dout_last      out  1   last payload word of packet (qualified by dout_valid)
//  dout_ready     in   1   consumer accepts when valid&&ready
//  pkt_type       out  8   header[7:0]; held from header accept until next header
//  pkt_id         out  16  id word; held likewise
//  pkt_start      out  1   1-cycle pulse when id word accepted
//  pkt_done       out  1   1-cycle pulse when checksum word consumed
//  pkt_err        out  3   {len_err, csum_err, magic_err}; valid with pkt_done, else 0
//  err_count      out  8   saturating count of bad packets + resync events
//  overflow       out  1   sticky: wr_en while buffer full (word dropped)
// BEHAVIOUR
//  Reset: all outputs 0; buffer empty; FSM in S_HDR; err_count=0; overflow=0.
//  Frame: HDR {MAGIC,type}, LEN (1..MAX_LEN), ID, LEN payload words, CSUM = 16-bit wrap sum of payload.
//  Buffer: write on wr_en; count updates with 1-cycle latency.
//   almost_full <= (count_next >= BUF_DEPTH-AF_MARGIN).
//   Simultaneous read+write: count unchanged.
//   Write when full: word dropped, overflow set sticky.
//  FSM pops one word per cycle when buffer non-empty, except S_DATA, which pops only when dout_ready or output reg empty.
//  S_HDR: [15:8]!=MAGIC -> drop word, magic_err latched, err_count++ once per resync run; stay.
//   Else latch type -> S_LEN.
//  S_LEN: 0 or >MAX_LEN -> pkt_done with len_err, err_count++ -> S_HDR. Else load remaining=LEN -> S_ID.
//  S_ID: latch id, pkt_start pulse, clear sum -> S_DATA.
//  S_DATA: 1-entry output register; sum += word; remaining--; dout_last when remaining==1 at load -> S_CSUM after last load.
//  S_CSUM: compare with sum; pkt_done pulse, csum_err if mismatch (err_count++); magic_err reported if resync preceded HDR -> S_HDR.
//  Latency: buffer write -> dout_valid >= 2 cycles. dout held stable while valid&&!ready.
//  err_count saturates at 8'hFF. Sum width 16, wraps.
//  Async rst mid-packet: immediate return to reset state; partial packet discarded, no pkt_done.
// STRUCTURE
//  Shared package: MAGIC default, state encoding (S_HDR,S_LEN,S_ID,S_DATA,S_CSUM), pkt_err bit positions.
//  Sub-module: inpkt_word_buf (BUF_DEPTH FIFO, count, almost_full, overflow); FSM and output register stay in top.
// TESTING
//  1. Good pkt: 5A01,0003,1234,0001,0002,0003,0006, ready=1 -> 3 payload words, last on 0003, pkt_start, pkt_done, pkt_err=0.
//  2. Same pkt with CSUM=0007 -> payload delivered, pkt_done with pkt_err=3'b010, err_count=1.
//  3. Junk 0000,FFFF before good pkt -> both dropped, err_count=1, packet then parses with pkt_err=3'b001.
//  4. LEN=0000, then LEN=MAX_LEN+1 -> pkt_done with len_err each time, err_count +1 each, next pkt parses.
//  5. dout_ready=0 with continuous wr_en -> almost_full at count 5 (depth 8); no overflow with 2-cycle writer lag; stream resumes in order.
//  6. rst asserted during S_DATA -> outputs 0 same cycle, buffer empty; fresh pkt afterwards parses correctly.

Source files
------------

// File: rtl/inpkt_parser_pkg.sv
// Shared definitions for the inbound packet parser: header magic,
// parser state encoding, status bit positions and a saturating counter helper.
package inpkt_parser_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'h5A;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LEN  = 3'd1,
        S_ID   = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4
    } state_t;

    // Positions inside pkt_err = {len_err, csum_err, magic_err}
    localparam int ERR_MAGIC = 0;
    localparam int ERR_CSUM  = 1;
    localparam int ERR_LEN   = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/inpkt_word_buf.sv
// Small word FIFO between the USB I/O block and the parser. The writer has no
// handshake, so almost_full is raised early enough to cover its write pipeline;
// a write that still arrives while full is dropped and flagged sticky.
module inpkt_word_buf
    import inpkt_parser_pkg::*;
#(
    parameter int BUF_DEPTH = 8,
    parameter int AF_MARGIN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        empty,
    output logic        almost_full,
    output logic        overflow
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] AF_LEVEL   = CW'(BUF_DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(BUF_DEPTH);

    logic [15:0]   mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (count == FULL_LEVEL);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle's write/read; a simultaneous pair cancels out.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, registered back-pressure and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
            count       <= count_next;
            almost_full <= (count_next >= AF_LEVEL);
            if (wr_en && full) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/inpkt_parser.sv
// Inbound packet parser: buffers the USB word stream, walks the
// HDR/LEN/ID/payload/CSUM frame, hands payload out through a one-entry
// output register and reports per-packet status.
//
//  state  | meaning
//  S_HDR  | hunting for {MAGIC,type}; non-magic words are dropped (resync)
//  S_LEN  | length word; 0 or above MAX_LEN ends the packet with len_err
//  S_ID   | id word; announces the packet and clears the running sum
//  S_DATA | payload words into the output register, summing as they pass
//  S_CSUM | checksum word compared against the sum; packet completes
module inpkt_parser
    import inpkt_parser_pkg::*;
#(
    parameter int         BUF_DEPTH = 8,
    parameter int         AF_MARGIN = 3,
    parameter int         MAX_LEN   = 1024,
    parameter logic [7:0] MAGIC     = MAGIC_DEFAULT
) (
    input  logic        IFCLK,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        wr_en,
    output logic        almost_full,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        dout_last,
    input  logic        dout_ready,
    output logic [7:0]  pkt_type,
    output logic [15:0] pkt_id,
    output logic        pkt_start,
    output logic        pkt_done,
    output logic [2:0]  pkt_err,
    output logic [7:0]  err_count,
    output logic        overflow
);

    localparam int          REM_W   = $clog2(MAX_LEN + 1);
    localparam logic [15:0] MAX_L16 = 16'(MAX_LEN);

    state_t             state;
    state_t             state_next;
    logic [15:0]        buf_word;
    logic               buf_empty;
    logic               pop;
    logic               load_out;
    logic               last_next;
    logic [REM_W-1:0]   remaining;
    logic [REM_W-1:0]   remaining_next;
    logic [15:0]        sum;
    logic [15:0]        sum_next;
    logic               resync;
    logic               resync_next;
    logic [7:0]         type_next;
    logic [15:0]        id_next;
    logic               start_next;
    logic               done_next;
    logic [2:0]         err_next;
    logic               err_inc;

    inpkt_word_buf #(
        .BUF_DEPTH (BUF_DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_buf (
        .clk         (IFCLK),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (pop),
        .rd_data     (buf_word),
        .empty       (buf_empty),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    // Parser state register.
    always_ff @(posedge IFCLK or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_next;
    end

    // Next state plus next values of every parser register; one word consumed per pop.
    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        load_out       = 1'b0;
        last_next      = 1'b0;
        remaining_next = remaining;
        sum_next       = sum;
        resync_next    = resync;
        type_next      = pkt_type;
        id_next        = pkt_id;
        start_next     = 1'b0;
        done_next      = 1'b0;
        err_next       = 3'b000;
        err_inc        = 1'b0;

        // Payload only moves when the output register has room or is being drained.
        if (!buf_empty && (state != S_DATA || !dout_valid || dout_ready)) begin
            pop = 1'b1;
            case (state)
                S_HDR: begin
                    if (buf_word[15:8] != MAGIC) begin
                        err_inc     = !resync;
                        resync_next = 1'b1;
                    end else begin
                        type_next  = buf_word[7:0];
                        state_next = S_LEN;
                    end
                end
                S_LEN: begin
                    if (buf_word == 16'h0000 || buf_word > MAX_L16) begin
                        done_next          = 1'b1;
                        err_next[ERR_LEN]  = 1'b1;
                        err_next[ERR_MAGIC] = resync;
                        resync_next        = 1'b0;
                        err_inc            = 1'b1;
                        state_next         = S_HDR;
                    end else begin
                        remaining_next = REM_W'(buf_word);
                        state_next     = S_ID;
                    end
                end
                S_ID: begin
                    id_next    = buf_word;
                    start_next = 1'b1;
                    sum_next   = 16'h0000;
                    state_next = S_DATA;
                end
                S_DATA: begin
                    load_out       = 1'b1;
                    sum_next       = sum + buf_word;
                    remaining_next = remaining - REM_W'(1);
                    last_next      = (remaining == REM_W'(1));
                    if (remaining == REM_W'(1)) state_next = S_CSUM;
                end
                S_CSUM: begin
                    done_next           = 1'b1;
                    err_next[ERR_CSUM]  = (buf_word != sum);
                    err_next[ERR_MAGIC] = resync;
                    err_inc             = (buf_word != sum);
                    resync_next         = 1'b0;
                    state_next          = S_HDR;
                end
                default: state_next = S_HDR;
            endcase
        end
    end

    // Packet bookkeeping and status outputs.
    always_ff @(posedge IFCLK or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            sum       <= 16'h0000;
            resync    <= 1'b0;
            pkt_type  <= 8'h00;
            pkt_id    <= 16'h0000;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 3'b000;
            err_count <= 8'h00;
        end else begin
            remaining <= remaining_next;
            sum       <= sum_next;
            resync    <= resync_next;
            pkt_type  <= type_next;
            pkt_id    <= id_next;
            pkt_start <= start_next;
            pkt_done  <= done_next;
            pkt_err   <= err_next;
            if (err_inc) err_count <= sat_inc8(err_count);
        end
    end

    // One-entry payload output register; holds its word until accepted.
    always_ff @(posedge IFCLK or posedge rst) begin
        if (rst) begin
            dout       <= 16'h0000;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else if (load_out) begin
            dout       <= buf_word;
            dout_valid <= 1'b1;
            dout_last  <= last_next;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inpkt_parser.sv
// Scoreboard bench for inpkt_parser: frames are built from the framing rules,
// expected payload/status is queued at send time and a monitor checks outputs.
module tb_inpkt_parser;

    localparam int MAX_LEN = 1024;

    logic        IFCLK = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        wr_en;
    logic        almost_full;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready;
    logic [7:0]  pkt_type;
    logic [15:0] pkt_id;
    logic        pkt_start;
    logic        pkt_done;
    logic [2:0]  pkt_err;
    logic [7:0]  err_count;
    logic        overflow;

    inpkt_parser dut (
        .IFCLK       (IFCLK),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .almost_full (almost_full),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_last   (dout_last),
        .dout_ready  (dout_ready),
        .pkt_type    (pkt_type),
        .pkt_id      (pkt_id),
        .pkt_start   (pkt_start),
        .pkt_done    (pkt_done),
        .pkt_err     (pkt_err),
        .err_count   (err_count),
        .overflow    (overflow)
    );

    always #5 IFCLK = ~IFCLK;

    typedef struct { logic [15:0] w; logic last; } dword_t;
    typedef struct { logic [7:0] typ; logic [15:0] id; logic [2:0] err; bit has_id; } pkt_t;
    typedef struct { logic [7:0] typ; logic [15:0] id; } start_t;

    dword_t      exp_dq[$];
    pkt_t        exp_pq[$];
    start_t      exp_sq[$];
    logic [15:0] tx_q[$];
    logic [15:0] pl_q[$];
    logic [15:0] junk_q[$];

    int checks = 0;
    int failures = 0;
    int err_model = 0;
    int wr_count = 0;
    int ready_mode = 1;
    bit gaps = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Build one frame from the framing rules and queue everything it should produce.
    task automatic send_pkt(input logic [7:0] typ, input logic [15:0] id,
                            input logic [15:0] len_word, input logic [15:0] csum_delta);
        pkt_t        p;
        start_t      s;
        dword_t      d;
        logic [15:0] sum;
        bit          len_bad;
        len_bad  = (len_word == 16'h0) || (len_word > 16'(MAX_LEN));
        p.typ    = typ;
        p.id     = id;
        p.has_id = !len_bad;
        p.err    = 3'b000;
        if (junk_q.size() != 0) begin
            p.err[0]  = 1'b1;
            err_model = sat(err_model);
        end
        foreach (junk_q[i]) tx_q.push_back(junk_q[i]);
        tx_q.push_back({8'h5A, typ});
        tx_q.push_back(len_word);
        if (len_bad) begin
            p.err[2]  = 1'b1;
            err_model = sat(err_model);
        end else begin
            tx_q.push_back(id);
            s.typ = typ;
            s.id  = id;
            exp_sq.push_back(s);
            sum = 16'h0;
            foreach (pl_q[i]) begin
                tx_q.push_back(pl_q[i]);
                sum    = sum + pl_q[i];
                d.w    = pl_q[i];
                d.last = (i == pl_q.size() - 1);
                exp_dq.push_back(d);
            end
            tx_q.push_back(sum + csum_delta);
            if (csum_delta != 16'h0) begin
                p.err[1]  = 1'b1;
                err_model = sat(err_model);
            end
        end
        exp_pq.push_back(p);
        junk_q.delete();
        pl_q.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || exp_dq.size() != 0 || exp_pq.size() != 0 || exp_sq.size() != 0)
               && n < 4000) begin
            @(negedge IFCLK);
            n++;
        end
        repeat (4) @(negedge IFCLK);
        check({name, "_drained"}, 64'(n < 4000), 64'd1);
        if (n >= 4000) begin
            tx_q.delete(); exp_dq.delete(); exp_pq.delete(); exp_sq.delete();
        end
        check({name, "_err_count"}, 64'(err_count), 64'(err_model));
        check({name, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    // Writer model: drives after each edge, reacts to almost_full two cycles late.
    initial begin
        logic af_h0, af_h1, af_h2;
        af_h0 = 1'b0; af_h1 = 1'b0; af_h2 = 1'b0;
        wr_en = 1'b0; din = 16'h0; dout_ready = 1'b0;
        forever begin
            @(posedge IFCLK);
            #1;
            if (wr_en) wr_count++;
            af_h2 = af_h1; af_h1 = af_h0; af_h0 = almost_full;
            case (ready_mode)
                0:       dout_ready = 1'b0;
                1:       dout_ready = 1'b1;
                default: dout_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (!rst && tx_q.size() != 0 && !af_h2 && (!gaps || $urandom_range(0, 9) < 7)) begin
                din   = tx_q.pop_front();
                wr_en = 1'b1;
            end else begin
                din   = 16'h0;
                wr_en = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        dword_t e;
        pkt_t   p;
        start_t s;
        forever begin
            @(negedge IFCLK);
            if (!rst) begin
                if (dout_valid && dout_ready) begin
                    if (exp_dq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_payload: got %h expected none", dout);
                    end else begin
                        e = exp_dq.pop_front();
                        check("dout", 64'(dout), 64'(e.w));
                        check("dout_last", 64'(dout_last), 64'(e.last));
                    end
                end
                if (pkt_start) begin
                    if (exp_sq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_pkt_start: got 1 expected 0");
                    end else begin
                        s = exp_sq.pop_front();
                        check("start_type", 64'(pkt_type), 64'(s.typ));
                        check("start_id", 64'(pkt_id), 64'(s.id));
                    end
                end
                if (pkt_done) begin
                    if (exp_pq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_pkt_done: got err %b expected no packet", pkt_err);
                    end else begin
                        p = exp_pq.pop_front();
                        check("pkt_err", 64'(pkt_err), 64'(p.err));
                        check("done_type", 64'(pkt_type), 64'(p.typ));
                        if (p.has_id) check("done_id", 64'(pkt_id), 64'(p.id));
                    end
                end else begin
                    check("pkt_err_idle", 64'(pkt_err), 64'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        int          plen;
        int          n;
        logic [7:0]  ty;
        logic [15:0] id16;
        logic [15:0] lw;
        logic [15:0] jw;

        rst = 1'b1;
        repeat (3) @(negedge IFCLK);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_almost_full", 64'(almost_full), 64'd0);
        check("rst_pkt_done", 64'(pkt_done), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_pkt_id", 64'(pkt_id), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge IFCLK);

        // Known-good frame, then the same frame with a bad checksum.
        ready_mode = 1;
        pl_q = '{16'h0001, 16'h0002, 16'h0003};
        send_pkt(8'h01, 16'h1234, 16'd3, 16'h0);
        wait_idle("good");
        pl_q = '{16'h0001, 16'h0002, 16'h0003};
        send_pkt(8'h01, 16'h1234, 16'd3, 16'h0001);
        wait_idle("bad_csum");

        // Junk ahead of a header.
        junk_q = '{16'h0000, 16'hFFFF};
        pl_q   = '{16'h0001, 16'h0002, 16'h0003};
        send_pkt(8'h01, 16'h1234, 16'd3, 16'h0);
        wait_idle("junk");

        // Length boundaries: 0 and MAX_LEN+1 rejected, then a normal frame.
        send_pkt(8'h22, 16'h0, 16'h0000, 16'h0);
        send_pkt(8'h23, 16'h0, 16'(MAX_LEN + 1), 16'h0);
        pl_q = '{16'hBEEF};
        send_pkt(8'h24, 16'hCAFE, 16'd1, 16'h0);
        wait_idle("len_err");

        // Randomised mix with random ready and writer gaps.
        ready_mode = 2;
        gaps = 1'b1;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            ty   = 8'($urandom);
            id16 = 16'($urandom);
            plen = $urandom_range(1, 8);
            if (kind == 9) begin
                lw = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom_range(MAX_LEN + 1, 65535));
                send_pkt(ty, id16, lw, 16'h0);
            end else begin
                if (kind >= 7) begin
                    for (int j = 0; j < $urandom_range(1, 3); j++) begin
                        jw = 16'($urandom);
                        if (jw[15:8] == 8'h5A) jw[15:8] = 8'hA5;
                        junk_q.push_back(jw);
                    end
                end
                for (int j = 0; j < plen; j++) pl_q.push_back(16'($urandom));
                send_pkt(ty, id16, 16'(plen), (kind == 6) ? 16'($urandom_range(1, 65535)) : 16'h0);
            end
        end
        wait_idle("random");

        // Longest legal payload.
        for (int j = 0; j < MAX_LEN; j++) pl_q.push_back(16'($urandom));
        send_pkt(8'h77, 16'h0400, 16'(MAX_LEN), 16'h0);
        wait_idle("max_len");

        // Consumer stalled with a continuous writer.
        ready_mode = 0;
        gaps = 1'b0;
        wr_count = 0;
        for (int j = 0; j < 20; j++) pl_q.push_back(16'($urandom));
        send_pkt(8'h55, 16'h5555, 16'd20, 16'h0);
        n = 0;
        while (!almost_full && n < 200) begin
            @(negedge IFCLK);
            n++;
        end
        // HDR, LEN, ID and the first payload word leave the buffer; af rises at 5 held words.
        check("af_onset_words", 64'(wr_count), 64'd9);
        repeat (12) @(negedge IFCLK);
        check("af_held", 64'(almost_full), 64'd1);
        check("stall_no_overflow", 64'(overflow), 64'd0);
        ready_mode = 2;
        gaps = 1'b1;
        wait_idle("stall");

        // Error counter saturation.
        for (int i = 0; i < 260; i++) send_pkt(8'(i), 16'h0, 16'h0000, 16'h0);
        pl_q = '{16'h0010};
        send_pkt(8'h99, 16'h0099, 16'd1, 16'h0003);
        wait_idle("saturate");
        check("err_count_sat", 64'(err_count), 64'hFF);

        // Asynchronous reset in the middle of a payload.
        ready_mode = 1;
        gaps = 1'b0;
        for (int j = 0; j < 30; j++) pl_q.push_back(16'($urandom));
        send_pkt(8'h3C, 16'h3C3C, 16'd30, 16'h0);
        n = 0;
        while (!dout_valid && n < 100) begin
            @(negedge IFCLK);
            n++;
        end
        check("rst_reached_data", 64'(dout_valid), 64'd1);
        repeat (3) @(negedge IFCLK);
        rst = 1'b1;
        tx_q.delete(); exp_dq.delete(); exp_pq.delete(); exp_sq.delete();
        err_model = 0;
        #1;
        check("midrst_outputs_zero",
              {8'h0, dout_valid, dout_last, pkt_start, pkt_done, almost_full, overflow,
               pkt_err, err_count, pkt_type, pkt_id, dout}, 64'd0);
        repeat (3) @(negedge IFCLK);
        rst = 1'b0;
        repeat (6) @(negedge IFCLK);
        check("post_rst_idle", 64'(dout_valid | pkt_done | pkt_start), 64'd0);
        pl_q = '{16'h1111, 16'h2222};
        send_pkt(8'h42, 16'h4242, 16'd2, 16'h0);
        wait_idle("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
